// File: rtl/reorder_queue_ooo.sv
// reorder_queue_ooo: per-port reorder buffer that issues sequential tags, accepts tagged
// responses out of order and releases them strictly in allocation order.
// Optional simulation checks: define REORDER_QUEUE_ASSERT_EN.
module reorder_queue_ooo #(
    parameter int WIDTH = 70,
    parameter int DEPTH = 32,
    localparam int TAG_BITS = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    output logic [TAG_BITS-1:0] index_tag,
    output logic                full,
    input  logic                wr_en,
    input  logic [WIDTH-1:0]    d,
    output logic [WIDTH-1:0]    q,
    output logic                valid,
    input  logic                stall
);
    localparam int IDX = TAG_BITS - 1;

    logic [TAG_BITS-1:0] head, tail, count, wr_off;
    logic [WIDTH-1:0]    storage [DEPTH];
    logic [DEPTH-1:0]    occupied, occ_next;
    logic [IDX-1:0]      head_slot, wr_slot;
    logic                alloc, wr_ok, rel;

    assign count     = tail - head;
    assign full      = count == TAG_BITS'(DEPTH);
    assign index_tag = tail;
    assign alloc     = rd_en && !full;
    assign wr_off    = d[TAG_BITS-1:0] - head;
    assign wr_ok     = wr_en && (wr_off < count);
    assign head_slot = head[IDX-1:0];
    assign wr_slot   = d[IDX-1:0];
    assign rel       = occupied[head_slot] && !stall;

    // Occupancy update; a release of the same slot wins so no stale bit survives head moving on
    always_comb begin
        occ_next = occupied;
        if (wr_ok) occ_next[wr_slot] = 1'b1;
        if (rel) occ_next[head_slot] = 1'b0;
    end

    // Response storage, written only for in-window tags
    always_ff @(posedge clk) begin
        if (wr_ok) storage[wr_slot] <= d;
    end

    // Pointers, occupancy and registered release output
    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            occupied <= '0;
            valid    <= 1'b0;
            q        <= '0;
        end else begin
            if (alloc) tail <= tail + TAG_BITS'(1);
            if (rel) head <= head + TAG_BITS'(1);
            if (rel) q <= storage[head_slot];
            valid    <= rel;
            occupied <= occ_next;
        end
    end

`ifdef REORDER_QUEUE_ASSERT_EN
    // Simulation-only protocol checks; report and continue
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (rd_en && full) $display("%t %m: rd_en while full", $time);
            if (wr_en && !wr_ok) $display("%t %m: wr_en tag %0d outside window", $time, d[TAG_BITS-1:0]);
            if (wr_ok && occupied[wr_slot]) $display("%t %m: wr_en to occupied slot %0d", $time, wr_slot);
        end
    end
`endif
endmodule

// File: tb/tb_reorder_queue_ooo.sv
// tb_reorder_queue_ooo: directed self-checking bench for reorder_queue_ooo.
module tb_reorder_queue_ooo;
    localparam int W = 70;
    localparam int TB = 6;

    logic          clk = 1'b0;
    logic          rst, rd_en, wr_en, stall;
    logic [W-1:0]  d, q;
    logic [TB-1:0] index_tag;
    logic          full, valid;
    int            n_cmp = 0;
    int            n_err = 0;
    logic [TB-1:0] exp_tail;

    reorder_queue_ooo dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .index_tag(index_tag), .full(full),
        .wr_en(wr_en), .d(d), .q(q), .valid(valid), .stall(stall)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(int data, logic [TB-1:0] tag);
        return {58'(data), tag};
    endfunction

    task automatic check(string tag, logic [W-1:0] got, logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; stall = 1'b0; d = '0;
        #1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_full", full, 0);
        check("rst_tag", index_tag, 0);
        check("rst_valid", valid, 0);
        check("rst_q", q, 0);

        // three allocations, responses 2,0,1
        for (int i = 0; i < 3; i++) begin
            check("alloc_tag", index_tag, i);
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        wr_en = 1'b1; d = mk(12, 2);
        tick();
        check("ooo_v0", valid, 0);
        d = mk(10, 0);
        tick();
        check("ooo_v1", valid, 0);
        d = mk(11, 1);
        tick();
        wr_en = 1'b0;
        check("ooo_vA", valid, 1);
        check("ooo_qA", q, mk(10, 0));
        tick();
        check("ooo_vB", valid, 1);
        check("ooo_qB", q, mk(11, 1));
        tick();
        check("ooo_vC", valid, 1);
        check("ooo_qC", q, mk(12, 2));
        tick();
        check("ooo_vend", valid, 0);
        check("ooo_qhold", q, mk(12, 2));

        // out-of-window write is dropped
        wr_en = 1'b1; d = mk(238, 3);
        tick();
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        tick();
        check("drop_v", valid, 0);
        wr_en = 1'b1; d = mk(13, 3);
        tick();
        wr_en = 1'b0;
        tick();
        check("late_v", valid, 1);
        check("late_q", q, mk(13, 3));

        // fill to full from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 32; i++) tick();
        check("fill_full", full, 1);
        check("fill_tag", index_tag, 32);
        tick();
        rd_en = 1'b0;
        check("over_full", full, 1);
        check("over_tag", index_tag, 32);

        // reverse responses under stall
        stall = 1'b1; wr_en = 1'b1;
        for (int t = 31; t >= 0; t--) begin
            d = mk(256 + t, TB'(t));
            tick();
        end
        wr_en = 1'b0;
        tick();
        tick();
        check("stall_v", valid, 0);
        check("stall_full", full, 1);
        stall = 1'b0;
        for (int t = 0; t < 32; t++) begin
            tick();
            check("rel_v", valid, 1);
            check("rel_q", q, mk(256 + t, TB'(t)));
            if (t == 0) check("rel_full", full, 0);
        end
        tick();
        check("rel_vend", valid, 0);

        // stall toggling every other cycle
        check("tog_tag0", index_tag, 32);
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rd_en = 1'b0; stall = 1'b1; wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = mk(512 + i, TB'(32 + i));
            tick();
        end
        wr_en = 1'b0;
        begin
            int k;
            k = 0;
            for (int i = 0; i < 8; i++) begin
                stall = i[0];
                tick();
                if (!stall) begin
                    check("tog_v", valid, 1);
                    check("tog_q", q, mk(512 + k, TB'(32 + k)));
                    k++;
                end else begin
                    check("tog_vs", valid, 0);
                end
            end
            stall = 1'b0;
            tick();
            check("tog_vend", valid, 0);
            check("tog_cnt", k, 4);
        end

        // wrap rounds
        exp_tail = 6'd36;
        for (int r = 0; r < 100; r++) begin
            check("wrap_tag", index_tag, exp_tail);
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0; wr_en = 1'b1; d = mk(r * 3 + 5, exp_tail);
            tick();
            wr_en = 1'b0;
            tick();
            check("wrap_v", valid, 1);
            check("wrap_q", q, mk(r * 3 + 5, exp_tail));
            exp_tail = exp_tail + 6'd1;
        end

        // reset mid-stream with 5 outstanding
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rd_en = 1'b0; wr_en = 1'b1; d = mk(77, exp_tail);
        tick();
        wr_en = 1'b1; d = mk(78, exp_tail + 6'd1);
        tick();
        wr_en = 1'b0;
        check("mid_v", valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_full", full, 0);
        check("mrst_tag", index_tag, 0);
        check("mrst_valid", valid, 0);
        check("mrst_q", q, 0);
        tick();
        tick();
        check("mrst_discard", valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
